// File: rtl/axis_frame_arb.sv
// Round-robin frame arbiter: four AXI-Stream requesters share one output, one whole frame at a time.
// Define AXIS_FRAME_ARB_DROP_COUNT_EN to add the drop_count output fed by drop_frame.
module axis_frame_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int PORTS      = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS*DATA_WIDTH-1:0] input_axis_tdata,
  input  logic [PORTS-1:0]            input_axis_tvalid,
  output logic [PORTS-1:0]            input_axis_tready,
  input  logic [PORTS-1:0]            input_axis_tlast,
  input  logic [PORTS-1:0]            input_axis_tuser,
  output logic [DATA_WIDTH-1:0]       output_axis_tdata,
  output logic                        output_axis_tvalid,
  input  logic                        output_axis_tready,
  output logic                        output_axis_tlast,
  output logic                        output_axis_tuser,
  input  logic                        drop_frame,
  output logic [1:0]                  grant,
  output logic                        busy,
`ifdef AXIS_FRAME_ARB_DROP_COUNT_EN
  output logic [15:0]                 frame_count,
  output logic [15:0]                 drop_count
`else
  output logic [15:0]                 frame_count
`endif
);

  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_ACTIVE = 1'b1;

  logic        state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic [1:0]  last_grant_q, last_grant_d;
  logic [15:0] frame_count_q, frame_count_d;

  logic [DATA_WIDTH-1:0] port_data [PORTS];
  logic                  active_ok;
  logic                  xfer;
  logic                  arb_found;
  logic [1:0]            arb_sel;
  logic [1:0]            arb_idx;

  // Outputs are forced quiet during reset so a mid-frame reset drops the beat immediately.
  assign active_ok = !rst && (state_q == STATE_ACTIVE);

  for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
    assign port_data[gi]         = input_axis_tdata[gi*DATA_WIDTH +: DATA_WIDTH];
    assign input_axis_tready[gi] = active_ok && (grant_q == 2'(gi)) && output_axis_tready;
  end

  assign output_axis_tdata  = port_data[grant_q];
  assign output_axis_tlast  = input_axis_tlast[grant_q];
  assign output_axis_tuser  = input_axis_tuser[grant_q];
  assign output_axis_tvalid = active_ok && input_axis_tvalid[grant_q];
  assign xfer               = output_axis_tvalid && output_axis_tready;

  // Search starts one past the last winner; k = PORTS wraps back to the last winner itself.
  always_comb begin
    arb_found = 1'b0;
    arb_sel   = 2'd0;
    arb_idx   = 2'd0;
    for (int k = 1; k <= PORTS; k++) begin
      arb_idx = last_grant_q + 2'(k);
      if (!arb_found && input_axis_tvalid[arb_idx]) begin
        arb_found = 1'b1;
        arb_sel   = arb_idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    last_grant_d  = last_grant_q;
    frame_count_d = frame_count_q;
    case (state_q)
      STATE_IDLE: begin
        if (arb_found) begin
          grant_d = arb_sel;
          state_d = STATE_ACTIVE;
        end
      end
      STATE_ACTIVE: begin
        if (xfer && output_axis_tlast) begin
          state_d       = STATE_IDLE;
          last_grant_d  = grant_q;
          frame_count_d = frame_count_q + 16'd1;
        end
      end
      default: state_d = STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= STATE_IDLE;
      grant_q       <= 2'd0;
      last_grant_q  <= 2'd3;
      frame_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      last_grant_q  <= last_grant_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign grant       = grant_q;
  assign busy        = (state_q == STATE_ACTIVE);
  assign frame_count = frame_count_q;

`ifdef AXIS_FRAME_ARB_DROP_COUNT_EN
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    drop_count_d = drop_count_q;
    if (drop_frame) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_count_q <= 16'd0;
    end else begin
      drop_count_q <= drop_count_d;
    end
  end

  assign drop_count = drop_count_q;
`else
  logic unused_drop_frame;
  assign unused_drop_frame = drop_frame;
`endif

endmodule

// File: tb/tb_axis_frame_arb.sv
// Scoreboard bench for axis_frame_arb: per-port driver queues feed the DUT, a monitor checks every output beat.
`timescale 1ns/1ps
module tb_axis_frame_arb;

  typedef struct packed {
    logic [1:0] port;
    logic [7:0] data;
    logic       last;
    logic       user;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic [3:0]  in_valid, in_ready, in_last, in_user;
  logic [7:0]  out_data;
  logic        out_valid, out_ready, out_last, out_user;
  logic        drop_frame;
  logic [1:0]  grant;
  logic        busy;
  logic [15:0] frame_count;
`ifdef AXIS_FRAME_ARB_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  always #5 clk = ~clk;

  axis_frame_arb #(.DATA_WIDTH(8), .PORTS(4)) dut (
    .clk                (clk),
    .rst                (rst),
    .input_axis_tdata   (in_data),
    .input_axis_tvalid  (in_valid),
    .input_axis_tready  (in_ready),
    .input_axis_tlast   (in_last),
    .input_axis_tuser   (in_user),
    .output_axis_tdata  (out_data),
    .output_axis_tvalid (out_valid),
    .output_axis_tready (out_ready),
    .output_axis_tlast  (out_last),
    .output_axis_tuser  (out_user),
    .drop_frame         (drop_frame),
    .grant              (grant),
    .busy               (busy),
`ifdef AXIS_FRAME_ARB_DROP_COUNT_EN
    .frame_count        (frame_count),
    .drop_count         (drop_count)
`else
    .frame_count        (frame_count)
`endif
  );

  beat_t pq [4][$];
  beat_t exp_q [$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cycle    = 0;
  int    gap_prev = -1;
  bit    gap_en   = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_in(input int p, input logic [7:0] d, input logic l, input logic u);
    beat_t b;
    b = '{port: 2'(p), data: d, last: l, user: u};
    pq[p].push_back(b);
  endtask

  task automatic push_exp(input int p, input logic [7:0] d, input logic l, input logic u);
    beat_t b;
    b = '{port: 2'(p), data: d, last: l, user: u};
    exp_q.push_back(b);
  endtask

  task automatic wait_grant(input logic [1:0] p, input string name);
    int i;
    i = 0;
    do begin
      @(negedge clk);
      i++;
    end while (!(busy && grant == p) && i < 50);
    check(name, 32'({busy, grant}), 32'({1'b1, p}));
  endtask

  task automatic wait_idle(input string name);
    int i;
    int pend;
    i = 0;
    do begin
      @(negedge clk);
      pend = exp_q.size();
      for (int p = 0; p < 4; p++) pend += pq[p].size();
      i++;
    end while ((busy || pend != 0) && i < 200);
    check(name, 32'({busy, pend != 0}), 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  // Driver: handshakes are sampled at the falling edge, queues advance just after the rising edge.
  initial begin
    logic [3:0] hs;
    in_valid = '0;
    in_data  = '0;
    in_last  = '0;
    in_user  = '0;
    forever begin
      @(negedge clk);
      hs = in_valid & in_ready;
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        if (hs[p]) void'(pq[p].pop_front());
        if (pq[p].size() != 0) begin
          in_valid[p]        = 1'b1;
          in_data[p*8 +: 8]  = pq[p][0].data;
          in_last[p]         = pq[p][0].last;
          in_user[p]         = pq[p][0].user;
        end else begin
          in_valid[p] = 1'b0;
          in_last[p]  = 1'b0;
          in_user[p]  = 1'b0;
        end
      end
    end
  end

  // Monitor: one line per output transfer, compared against the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        $display("xfer t=%0t port=%0d data=0x%02h last=%0b user=%0b", $time, grant, out_data, out_last, out_user);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%02h from port %0d, required no beat", out_data, grant);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_port", 32'(grant), 32'(mon_e.port));
          check("out_data", 32'(out_data), 32'(mon_e.data));
          check("out_last", 32'(out_last), 32'(mon_e.last));
          check("out_user", 32'(out_user), 32'(mon_e.user));
        end
        if (gap_en) begin
          if (gap_prev >= 0) check("bubble_gap", 32'(cycle - gap_prev), 32'd2);
          gap_prev = cycle;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    out_ready  = 1'b1;
    drop_frame = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);

    check("reset_busy", 32'(busy), 32'd0);
    check("reset_grant", 32'(grant), 32'd0);
    check("reset_frame_count", 32'(frame_count), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
`ifdef AXIS_FRAME_ARB_DROP_COUNT_EN
    check("reset_drop_count", 32'(drop_count), 32'd0);
`endif

    // Port 2 alone sends 0x11,0x22,0x33.
    push_in(2, 8'h11, 1'b0, 1'b0);
    push_in(2, 8'h22, 1'b0, 1'b0);
    push_in(2, 8'h33, 1'b1, 1'b0);
    push_exp(2, 8'h11, 1'b0, 1'b0);
    push_exp(2, 8'h22, 1'b0, 1'b0);
    push_exp(2, 8'h33, 1'b1, 1'b0);
    @(negedge clk);
    check("s1_valid_before_grant", 32'({in_valid[2], busy}), 32'b10);
    @(negedge clk);
    check("s1_grant_next_cycle", 32'({busy, grant}), 32'({1'b1, 2'd2}));
    wait_idle("s1_idle");
    check("s1_frame_count", 32'(frame_count), 32'd1);

    // All ports continuously valid with 1-beat frames: rotation 0,1,2,3 and a bubble between beats.
    do_reset();
    check("s2_reset_frame_count", 32'(frame_count), 32'd0);
    gap_en   = 1'b1;
    gap_prev = -1;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < 4; p++) begin
        push_in(p, 8'(8'h10 + p), 1'b1, 1'b0);
        push_exp(p, 8'(8'h10 + p), 1'b1, 1'b0);
      end
    end
    wait_idle("s2_idle");
    gap_en = 1'b0;
    check("s2_frame_count", 32'(frame_count), 32'd8);

    // Port 1 mid-frame while port 0 requests; port 0 waits for port 1's last beat.
    for (int i = 0; i < 4; i++) begin
      push_in(1, 8'(8'h31 + i), (i == 3), 1'b0);
      push_exp(1, 8'(8'h31 + i), (i == 3), 1'b0);
    end
    push_exp(0, 8'h01, 1'b0, 1'b0);
    push_exp(0, 8'h02, 1'b1, 1'b1);
    wait_grant(2'd1, "s3_grant_port1");
    push_in(0, 8'h01, 1'b0, 1'b0);
    push_in(0, 8'h02, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s3_port0_waiting", 32'({in_valid[0], in_ready[0]}), 32'b10);
      check("s3_grant_held", 32'(grant), 32'd1);
    end
    wait_grant(2'd0, "s3_grant_port0");
    wait_idle("s3_idle");
    check("s3_frame_count", 32'(frame_count), 32'd10);

    // Output stalls for three cycles mid-frame.
    for (int i = 0; i < 4; i++) begin
      push_in(2, 8'(8'h41 + i), (i == 3), 1'b0);
      push_exp(2, 8'(8'h41 + i), (i == 3), 1'b0);
    end
    wait_grant(2'd2, "s4_grant_port2");
    @(posedge clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("s4_tready_stalled", 32'(in_ready[2]), 32'd0);
      check("s4_beat_held", 32'({out_valid, out_data}), 32'({1'b1, 8'h42}));
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_idle("s4_idle");
    check("s4_frame_count", 32'(frame_count), 32'd11);

    // Reset pulse during beat 2 of a port 3 frame; port 0 wins afterwards.
    do_reset();
    check("s5_start_frame_count", 32'(frame_count), 32'd0);
    push_in(3, 8'hA0, 1'b0, 1'b0);
    push_in(3, 8'hA1, 1'b0, 1'b0);
    push_in(3, 8'hA2, 1'b1, 1'b0);
    push_exp(3, 8'hA0, 1'b0, 1'b0);
    push_exp(0, 8'hB0, 1'b1, 1'b0);
    push_exp(3, 8'hA1, 1'b0, 1'b0);
    push_exp(3, 8'hA2, 1'b1, 1'b0);
    wait_grant(2'd3, "s5_grant_port3");
    push_in(0, 8'hB0, 1'b1, 1'b0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("s5_rst_out_valid", 32'(out_valid), 32'd0);
    check("s5_rst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("s5_after_rst_idle", 32'({busy, frame_count}), 32'd0);
    @(negedge clk);
    check("s5_grant_port0", 32'({busy, grant}), 32'({1'b1, 2'd0}));
    wait_idle("s5_idle");
    check("s5_frame_count", 32'(frame_count), 32'd2);

    // Drop pulses: counted when the drop counter is built, otherwise ignored.
    @(posedge clk);
    #1 drop_frame = 1'b1;
    @(posedge clk);
    #1 drop_frame = 1'b0;
    @(posedge clk);
    #1 drop_frame = 1'b1;
    @(posedge clk);
    #1 drop_frame = 1'b0;
    @(negedge clk);
    check("s6_frame_count_unaffected", 32'({busy, frame_count}), 32'd2);
`ifdef AXIS_FRAME_ARB_DROP_COUNT_EN
    check("s6_drop_count", 32'(drop_count), 32'd2);
    do_reset();
    check("s6_drop_count_reset", 32'(drop_count), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
